// File: rtl/pixel_readout_scheduler_if.sv
// Byte-wide valid/ready packet stream between the readout scheduler and the pad serializer.
interface pixel_readout_scheduler_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pixel_readout_scheduler.sv
// Round-robin readout of per-pixel period captures as framed packets (header + period bytes).
// Optional trailing XOR checksum beat enabled by defining PIXEL_READOUT_CHECKSUM_EN.
module pixel_readout_scheduler #(
   parameter int PIXELS       = 8,
   parameter int COUNTER_BITS = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [PIXELS*COUNTER_BITS-1:0] period_in,
   input  logic [PIXELS-1:0]              period_valid,
   input  logic                           clear_overrun,
   pixel_readout_scheduler_if.master      out_if,
   output logic [PIXELS-1:0]              pending,
   output logic [PIXELS-1:0]              overrun
);
   localparam int PAYLOAD_BYTES = (COUNTER_BITS + 7) / 8;
   localparam int TX_BITS       = PAYLOAD_BYTES * 8;
   localparam int PTR_W         = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int CW            = PTR_W + 1;
   localparam int IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(PIXELS - 1);
`ifdef PIXEL_READOUT_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2, CHECK = 2'd3} state_t;

   // idx counts bytes from the most significant end of the tx register
   function automatic logic [7:0] tx_byte(input logic [TX_BITS-1:0] v, input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
         b = (idx == IDX_W'(PAYLOAD_BYTES - 1 - k)) ? v[k*8 +: 8] : b;
      end
      return b;
   endfunction

   logic [COUNTER_BITS-1:0] cap_r [PIXELS];
   logic [PIXELS-1:0]       pending_r;
   logic [PIXELS-1:0]       overrun_r;
   state_t                  state_r;
   logic [PTR_W-1:0]        ptr_r;
   logic [TX_BITS-1:0]      tx_r;
   logic [IDX_W-1:0]        byte_idx_r;
   logic [7:0]              csum_r;
   logic [7:0]              out_data_r;
   logic                    out_valid_r;
   logic                    out_last_r;

   logic                    grant_found_s;
   logic [PTR_W-1:0]        grant_idx_s;
   logic [CW-1:0]           cand_wide_s;
   logic [PTR_W-1:0]        cand_s;
   logic                    hit_s;
   logic                    grant_fire_s;
   logic [PIXELS-1:0]       grant_sel_s;

   // Pick the first pending channel at or after the round-robin pointer
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_wide_s   = '0;
      cand_s        = '0;
      hit_s         = 1'b0;
      for (int k = 0; k < PIXELS; k++) begin
         cand_wide_s   = {1'b0, ptr_r} + CW'(k);
         cand_s        = (cand_wide_s >= CW'(PIXELS)) ? PTR_W'(cand_wide_s - CW'(PIXELS))
                                                      : cand_wide_s[PTR_W-1:0];
         hit_s         = !grant_found_s && pending_r[cand_s];
         grant_idx_s   = hit_s ? cand_s : grant_idx_s;
         grant_found_s = grant_found_s | hit_s;
      end
   end

   assign grant_fire_s = (state_r == IDLE) && enable && grant_found_s;

   // One-hot view of the channel being granted this cycle
   always_comb begin
      grant_sel_s = '0;
      for (int i = 0; i < PIXELS; i++) begin
         grant_sel_s[i] = grant_fire_s && (grant_idx_s == PTR_W'(i));
      end
   end

   // Capture registers, pending flags and sticky overrun flags; a fresh capture beats a grant clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIXELS; i++) begin
            cap_r[i] <= '0;
         end
         pending_r <= '0;
         overrun_r <= '0;
      end else begin
         for (int i = 0; i < PIXELS; i++) begin
            if (period_valid[i]) begin
               cap_r[i]     <= period_in[i*COUNTER_BITS +: COUNTER_BITS];
               pending_r[i] <= 1'b1;
            end else if (grant_sel_s[i]) begin
               pending_r[i] <= 1'b0;
            end
            if (period_valid[i] && pending_r[i] && !grant_sel_s[i]) begin
               overrun_r[i] <= 1'b1;
            end else if (clear_overrun) begin
               overrun_r[i] <= 1'b0;
            end
         end
      end
   end

   // Packet FSM with registered stream outputs; outputs only move on a handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         tx_r        <= '0;
         byte_idx_r  <= '0;
         csum_r      <= 8'h00;
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_fire_s) begin
                  tx_r        <= TX_BITS'(cap_r[grant_idx_s]);
                  ptr_r       <= (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + PTR_W'(1);
                  out_data_r  <= {3'b101, 5'(grant_idx_s)};
                  csum_r      <= {3'b101, 5'(grant_idx_s)};
                  out_valid_r <= 1'b1;
                  out_last_r  <= 1'b0;
                  state_r     <= HEADER;
               end
            end
            HEADER: begin
               if (out_if.out_ready) begin
                  byte_idx_r <= '0;
                  out_data_r <= tx_byte(tx_r, '0);
                  out_last_r <= !CSUM_EN && (PAYLOAD_BYTES == 1);
                  state_r    <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (out_if.out_ready) begin
                  csum_r <= csum_r ^ out_data_r;
                  if (byte_idx_r == LAST_IDX) begin
`ifdef PIXEL_READOUT_CHECKSUM_EN
                     out_data_r  <= csum_r ^ out_data_r;
                     out_last_r  <= 1'b1;
                     state_r     <= CHECK;
`else
                     out_data_r  <= 8'h00;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                     state_r     <= IDLE;
`endif
                  end else begin
                     byte_idx_r <= byte_idx_r + IDX_W'(1);
                     out_data_r <= tx_byte(tx_r, byte_idx_r + IDX_W'(1));
                     out_last_r <= !CSUM_EN && ((byte_idx_r + IDX_W'(1)) == LAST_IDX);
                  end
               end
            end
            CHECK: begin
               if (out_if.out_ready) begin
                  out_data_r  <= 8'h00;
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_data_r  <= 8'h00;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign out_if.out_data  = out_data_r;
   assign out_if.out_valid = out_valid_r;
   assign out_if.out_last  = out_last_r;
   assign pending          = pending_r;
   assign overrun          = overrun_r;
endmodule

// File: tb/tb_pixel_readout_scheduler.sv
// Directed bench for pixel_readout_scheduler: packet-level reference model plus literal packet checks.
module tb_pixel_readout_scheduler;
   localparam int PIXELS = 8;
   localparam int CB     = 12;
   localparam int PB     = 2;
`ifdef PIXEL_READOUT_CHECKSUM_EN
   localparam int PL = PB + 2;
`else
   localparam int PL = PB + 1;
`endif

   typedef struct packed {logic [7:0] data; logic last;} beat_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   enable = 1'b1;
   logic                   clear_overrun = 1'b0;
   logic                   out_ready = 1'b1;
   logic [PIXELS*CB-1:0]   period_in = '0;
   logic [PIXELS-1:0]      period_valid = '0;
   logic [PIXELS-1:0]      pending;
   logic [PIXELS-1:0]      overrun;

   pixel_readout_scheduler_if bus();
   assign bus.out_ready = out_ready;

   pixel_readout_scheduler #(.PIXELS(PIXELS), .COUNTER_BITS(CB)) dut (
      .clk(clk), .rst(rst), .enable(enable), .period_in(period_in),
      .period_valid(period_valid), .clear_overrun(clear_overrun),
      .out_if(bus.master), .pending(pending), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   beat_t      exp_q[$];
   logic [7:0] log_q[$];
   logic       last_q[$];
   bit         m_pend[PIXELS];
   bit         m_ovr[PIXELS];
   int         m_val[PIXELS];
   int         m_ptr;
   bit         m_busy;
   bit         started = 0;

   task automatic push_packet(input int g, input int v);
      logic [7:0] bytes[$];
      logic [7:0] x;
      bytes.push_back(8'hA0 + 8'(g));
      for (int k = PB - 1; k >= 0; k--) bytes.push_back(8'((v >> (8 * k)) & 255));
`ifdef PIXEL_READOUT_CHECKSUM_EN
      x = 8'h00;
      foreach (bytes[j]) x = x ^ bytes[j];
      bytes.push_back(x);
`endif
      foreach (bytes[j]) exp_q.push_back({bytes[j], (j == bytes.size() - 1)});
   endtask

   always @(posedge clk) begin : model
      bit    old_pend[PIXELS];
      int    g;
      bit    granted;
      beat_t b;
      started = 1;
      if (rst) begin
         for (int i = 0; i < PIXELS; i++) begin
            m_pend[i] = 0; m_ovr[i] = 0; m_val[i] = 0;
         end
         m_ptr = 0; m_busy = 0;
         exp_q.delete();
      end else begin
         granted = 0;
         g = -1;
         if (m_busy) begin
            if (out_ready && exp_q.size() > 0) begin
               b = exp_q.pop_front();
               if (b.last) m_busy = 0;
            end
         end else if (enable) begin
            for (int k = 0; k < PIXELS; k++) begin
               if (g < 0 && m_pend[(m_ptr + k) % PIXELS]) g = (m_ptr + k) % PIXELS;
            end
            if (g >= 0) begin
               granted = 1;
               push_packet(g, m_val[g]);
               m_busy = 1;
               m_ptr = (g + 1) % PIXELS;
            end
         end
         old_pend = m_pend;
         for (int i = 0; i < PIXELS; i++) begin
            if (granted && i == g) m_pend[i] = 0;
            if (period_valid[i] && old_pend[i] && !(granted && i == g)) m_ovr[i] = 1;
            else if (clear_overrun) m_ovr[i] = 0;
            if (period_valid[i]) begin
               m_val[i] = int'(period_in[i*CB +: CB]);
               m_pend[i] = 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of accepted beats
   always @(negedge clk) begin
      logic [PIXELS-1:0] mp;
      logic [PIXELS-1:0] mo;
      if (started) begin
         for (int i = 0; i < PIXELS; i++) begin
            mp[i] = m_pend[i];
            mo[i] = m_ovr[i];
         end
         check("model_valid", bus.out_valid, m_busy);
         check("model_pending", pending, mp);
         check("model_overrun", overrun, mo);
         if (m_busy) begin
            if (exp_q.size() > 0) check("model_beat", {bus.out_data, bus.out_last}, exp_q[0]);
            else check("model_beat_missing", 1, 0);
         end
         if (bus.out_valid && out_ready) begin
            log_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch, input logic [CB-1:0] v);
      period_in[ch*CB +: CB] = v;
      period_valid[ch] = 1'b1;
      tick();
      period_valid = '0;
   endtask

   task automatic clear_log();
      log_q.delete();
      last_q.delete();
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int c = 0;
      while (log_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(name, (log_q.size() >= n), 1);
      repeat (3) tick();
   endtask

   task automatic wait_valid(input int budget, input string name);
      int c = 0;
      while (!bus.out_valid && c < budget) begin
         tick();
         c++;
      end
      check(name, bus.out_valid, 1);
   endtask

   task automatic check_log(input int k, input logic [7:0] v, input logic l, input string name);
      logic [7:0] a;
      logic       al;
      a  = (k < log_q.size()) ? log_q[k] : 8'hxx;
      al = (k < last_q.size()) ? last_q[k] : 1'bx;
      check(name, {a, al}, {v, l});
   endtask

   task automatic check_packet(input int base, input logic [7:0] hdr, input logic [CB-1:0] v,
                               input logic [7:0] csum, input string name);
      logic [15:0] p;
      p = 16'(v);
      check_log(base, hdr, 1'b0, name);
      check_log(base + 1, p[15:8], 1'b0, name);
      check_log(base + 2, p[7:0], (PL == 3), name);
      if (PL == 4) check_log(base + 3, csum, 1'b1, name);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset and idle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (20) tick();
      check("idle_valid", bus.out_valid, 0);
      check("idle_pending", pending, 0);
      check("idle_overrun", overrun, 0);

      // single packet on channel 3
      clear_log();
      pulse(3, 12'hABC);
      check("single_pend_set", pending[3], 1);
      tick();
      check("single_pend_clear", pending[3], 0);
      check("single_hdr", {bus.out_valid, bus.out_data}, {1'b1, 8'hA3});
      wait_log(PL, 20, "single_len");
      check_packet(0, 8'hA3, 12'hABC, 8'h15, "single_pkt");

      // round-robin over all channels from a fresh pointer
      rst = 1'b1; tick(); rst = 1'b0;
      clear_log();
      for (int i = 0; i < PIXELS; i++) period_in[i*CB +: CB] = CB'(12'h100 + i);
      period_valid = '1;
      tick();
      period_valid = '0;
      wait_log(PIXELS * PL, 100, "rr_len");
      for (int i = 0; i < PIXELS; i++) begin
         check_packet(i * PL, 8'hA0 + 8'(i), CB'(12'h100 + i), 8'hA1 ^ 8'(i) ^ 8'(i), "rr_pkt");
      end
      clear_log();
      period_in[0*CB +: CB] = 12'h0C0;
      period_in[5*CB +: CB] = 12'h5C5;
      period_valid = 8'b0010_0001;
      tick();
      period_valid = '0;
      wait_log(2 * PL, 30, "rr_wrap_len");
      check_packet(0, 8'hA0, 12'h0C0, 8'h60, "rr_wrap_first");
      check_packet(PL, 8'hA5, 12'h5C5, 8'h65, "rr_wrap_second");

      // backpressure in the middle of the payload
      clear_log();
      out_ready = 1'b0;
      pulse(6, 12'h5A5);
      wait_valid(10, "bp_valid");
      check("bp_hdr", bus.out_data, 8'hA6);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, 1'b0, 8'h05});
      end
      out_ready = 1'b1;
      wait_log(PL, 20, "bp_len");
      check_packet(0, 8'hA6, 12'h5A5, 8'h06, "bp_pkt");

      // overrun while disabled, clear, then grant/capture collision
      clear_log();
      enable = 1'b0;
      pulse(2, 12'h111);
      pulse(2, 12'h222);
      check("ovr_set", overrun[2], 1);
      check("ovr_pending", pending[2], 1);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      check("ovr_clear", overrun, 0);
      enable = 1'b1;
      pulse(2, 12'h333);
      check("coll_pending", pending[2], 1);
      check("coll_no_ovr", overrun[2], 0);
      check("coll_hdr", {bus.out_valid, bus.out_data}, {1'b1, 8'hA2});
      wait_log(2 * PL, 30, "coll_len");
      check_packet(0, 8'hA2, 12'h222, 8'h82, "coll_old");
      check_packet(PL, 8'hA2, 12'h333, 8'h92, "coll_new");

      // reset in the middle of a packet, then a fresh packet
      clear_log();
      pulse(1, 12'h0F0);
      wait_valid(10, "rstmid_valid");
      tick();
      rst = 1'b1;
      tick();
      check("rstmid_valid_low", bus.out_valid, 0);
      check("rstmid_pending", pending, 0);
      rst = 1'b0;
      clear_log();
      pulse(4, 12'h7E7);
      wait_log(PL, 20, "rstmid_len");
      check_packet(0, 8'hA4, 12'h7E7, 8'h44, "rstmid_pkt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pixel_readout_scheduler.md
Name: pixel_readout_scheduler

Overview:
Round-robin scheduler that shares one byte-wide output port among the per-pixel frequency counters. Each counter reports a new period measurement with a one-cycle pulse. The block captures the value, queues it as pending, and emits it as a framed packet (header + period bytes) over a valid/ready stream. It sits between the per-pixel counter array and the pad-level serializer/output mux.

Parameters:
PIXELS, 8, number of requesting pixel channels (1..32)
COUNTER_BITS, 12, width of each period value (1..32)
PAYLOAD_BYTES, derived = ceil(COUNTER_BITS/8), period bytes per packet (not overridable)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
ENABLE  in  1  permits new grants; a packet already in progress always completes
PERIOD_IN  in  PIXELS*COUNTER_BITS  packed periods; channel i at [i*COUNTER_BITS +: COUNTER_BITS]
PERIOD_VALID  in  PIXELS  one-cycle pulse per channel: new period available
CLEAR_OVERRUN  in  1  clears all OVERRUN bits
OUT_DATA  out  8  packet byte
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts the byte when OUT_VALID && OUT_READY
OUT_LAST  out  1  marks the final byte of the packet
PENDING  out  PIXELS  captured value waiting for transmission, per channel
OVERRUN  out  PIXELS  sticky: an untransmitted value was overwritten

Behaviour:
- Reset (RST high at a CLK edge): FSM=IDLE; OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, PENDING=0, OVERRUN=0, capture registers=0, round-robin pointer=0 (channel 0 has highest priority). RST overrides every other input, including mid-packet; the partial packet is abandoned.
- Capture: on PERIOD_VALID[i], the capture register for channel i takes its PERIOD_IN slice and PENDING[i] is set on the next edge. A repeat capture overwrites the older value; latest value wins.
- Overrun: PERIOD_VALID[i] while PENDING[i]=1 and channel i is not being granted that cycle sets OVERRUN[i]. If CLEAR_OVERRUN and a new overrun occur together, the set wins for that bit.
- Arbitration, only in IDLE with ENABLE=1 and PENDING!=0:
  - Grant the first pending channel at or after the pointer, wrapping modulo PIXELS.
  - Copy its capture register into the tx register and clear PENDING[g].
  - Set the pointer to (g+1) mod PIXELS.
  - Go to HEADER.
- Grant/capture collision: if PERIOD_VALID[g] fires in the grant cycle, the old value is transmitted, the new value is captured, PENDING[g] stays 1, and OVERRUN is not set.
- FSM states:
  - IDLE: OUT_VALID=0.
  - HEADER: OUT_DATA = {3'b101, g[4:0]}, OUT_VALID=1. On handshake, go to PAYLOAD with byte index 0.
  - PAYLOAD: OUT_DATA = tx byte (PAYLOAD_BYTES-1-idx), i.e. MSB byte first, period zero-extended to PAYLOAD_BYTES*8. OUT_LAST=1 on the final byte. After the final handshake, go to IDLE.
- Outputs are registered. OUT_DATA, OUT_VALID and OUT_LAST hold stable while OUT_VALID=1 and OUT_READY=0. OUT_VALID never drops without a handshake (except on RST).
- Timing:
  - Latency from grant cycle to header valid: 1 cycle.
  - Packet length: 1+PAYLOAD_BYTES beats.
  - At least 1 IDLE cycle between packets.
  - With OUT_READY held high and default parameters: 3 data cycles + 1 idle = 4 cycles/packet.
- ENABLE low: no grants. Captures, PENDING and OVERRUN continue to update.

Optional Feature:
PIXEL_READOUT_CHECKSUM_EN:
- Defined: one extra beat after the payload, OUT_DATA = XOR of the header and all payload bytes. OUT_LAST moves to this beat; packet length is 2+PAYLOAD_BYTES.
- Undefined: no checksum beat; OUT_LAST on the last payload byte.

Test Plan:
- Reset/idle: hold RST 2 cycles, release, no PERIOD_VALID -> OUT_VALID=0, PENDING=0, OVERRUN=0 for 20 cycles.
- Single packet: PERIOD_VALID[3] with slice 0xABC, OUT_READY=1 -> bytes 0xA3, 0x0A, 0xBC; OUT_LAST only on 0xBC; PENDING[3] 1→0 at grant. With CHECKSUM_EN: a fourth byte 0x15 carries OUT_LAST.
- Round-robin fairness: pulse all 8 channels in one cycle, values 0x100+i -> headers 0xA0..0xA7 in order. Then pulse channels 0 and 5 together -> 0xA0 first (pointer wrapped to 0), then 0xA5.
- Backpressure: OUT_READY=0 for 10 cycles mid-payload -> OUT_DATA/OUT_VALID/OUT_LAST constant. Packet resumes correctly when OUT_READY=1.
- Overrun and collision:
  - ENABLE=0, two pulses on channel 2 (0x111 then 0x222) -> OVERRUN[2]=1.
  - ENABLE=1 -> packet carries 0x222.
  - Pulse in the grant cycle -> no new overrun, PENDING[2] stays 1.
  - CLEAR_OVERRUN -> OVERRUN=0.
- Reset mid-packet: assert RST after the header handshake -> the next cycle shows OUT_VALID=0 and PENDING=0. A fresh request then produces a complete packet starting with a header.
